// File: rtl/pd_ctrl_pkg.sv
// rtl/pd_ctrl_pkg.sv - shared types, constants and output decode for the power-domain switch controller
package pd_ctrl_pkg;

  localparam int PD_CNT_W           = 16;
  localparam int PD_ISO_CYC_DEF     = 4;
  localparam int PD_ACK_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    ST_ON,
    ST_ISO_SET,
    ST_RST_SET,
    ST_SW_OFF,
    ST_OFF,
    ST_SW_ON,
    ST_RST_REL,
    ST_ISO_REL
  } pd_state_e;

  typedef struct packed {
    logic switch_n;
    logic iso_n;
    logic dom_rst_n;
    logic powered;
    logic busy;
  } pd_out_t;

  // Moore output decode, applied to the next state so the output flops line up with the state flops.
  function automatic pd_out_t pd_decode(input pd_state_e s);
    pd_out_t o;
    o = '{switch_n: 1'b0, iso_n: 1'b0, dom_rst_n: 1'b0, powered: 1'b0, busy: 1'b1};
    case (s)
      ST_ON:      o = '{switch_n: 1'b0, iso_n: 1'b1, dom_rst_n: 1'b1, powered: 1'b1, busy: 1'b0};
      ST_ISO_SET: o.dom_rst_n = 1'b1;
      ST_RST_SET: o.dom_rst_n = 1'b0;
      ST_SW_OFF:  o.switch_n  = 1'b1;
      ST_OFF:     o = '{switch_n: 1'b1, iso_n: 1'b0, dom_rst_n: 1'b0, powered: 1'b0, busy: 1'b0};
      ST_SW_ON:   o.switch_n  = 1'b0;
      ST_RST_REL: o.dom_rst_n = 1'b1;
      ST_ISO_REL: o = '{switch_n: 1'b0, iso_n: 1'b1, dom_rst_n: 1'b1, powered: 1'b0, busy: 1'b1};
      default:    o = '{switch_n: 1'b0, iso_n: 1'b1, dom_rst_n: 1'b1, powered: 1'b1, busy: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pd_ack_sync.sv
// rtl/pd_ack_sync.sv - two-flop synchronizer for the asynchronous power-switch ack
module pd_ack_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta <= 1'b0;
      q_o  <= 1'b0;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/pd_switch_ctrl.sv
// rtl/pd_switch_ctrl.sv - power-domain switch sequencer (isolation, reset, switch, ack timeout)
// Define PD_ACK_SYNC_EN to route switch_ack_ni through pd_ack_sync before the FSM.
module pd_switch_ctrl
  import pd_ctrl_pkg::*;
#(
  parameter int ISO_CYC     = PD_ISO_CYC_DEF,
  parameter int ACK_TIMEOUT = PD_ACK_TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pd_req_i,
  input  logic err_clr_i,
  input  logic switch_ack_ni,
  output logic switch_no,
  output logic iso_no,
  output logic dom_rst_no,
  output logic powered_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o
);

  localparam logic [PD_CNT_W-1:0] ISO_LAST = PD_CNT_W'(ISO_CYC - 1);
  localparam logic [PD_CNT_W-1:0] TO_LAST  = PD_CNT_W'(ACK_TIMEOUT - 1);

  logic                ack_s;
  pd_state_e           state, state_d;
  logic [PD_CNT_W-1:0] cnt;
  pd_out_t             out_d;

`ifdef PD_ACK_SYNC_EN
  pd_ack_sync u_ack_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (switch_ack_ni),
    .q_o   (ack_s)
  );
`else
  assign ack_s = switch_ack_ni;
`endif

  always_comb begin
    state_d = state;
    case (state)
      ST_ON:      if (pd_req_i)       state_d = ST_ISO_SET;
      ST_ISO_SET: if (cnt == ISO_LAST) state_d = ST_RST_SET;
      ST_RST_SET:                      state_d = ST_SW_OFF;
      ST_SW_OFF:  if (ack_s)           state_d = ST_OFF;
      ST_OFF:     if (!pd_req_i)       state_d = ST_SW_ON;
      ST_SW_ON:   if (!ack_s)          state_d = ST_RST_REL;
      ST_RST_REL: if (cnt == ISO_LAST) state_d = ST_ISO_REL;
      ST_ISO_REL:                      state_d = ST_ON;
      default:                         state_d = ST_ON;
    endcase
  end

  assign out_d = pd_decode(state_d);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_ON;
      cnt        <= '0;
      switch_no  <= 1'b0;
      iso_no     <= 1'b1;
      dom_rst_no <= 1'b1;
      powered_o  <= 1'b1;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= (state_d != state) ? '0 : ((cnt == '1) ? cnt : cnt + 1'b1);
      switch_no  <= out_d.switch_n;
      iso_no     <= out_d.iso_n;
      dom_rst_no <= out_d.dom_rst_n;
      powered_o  <= out_d.powered;
      busy_o     <= out_d.busy;
      done_o     <= (state_d == ST_ON || state_d == ST_OFF) && (state != ST_ON && state != ST_OFF);
      // Timeout set takes priority over a same-cycle clear.
      if ((state == ST_SW_OFF || state == ST_SW_ON) && cnt == TO_LAST)
        err_o <= 1'b1;
      else if (err_clr_i)
        err_o <= 1'b0;
    end
  end

endmodule
